// File: rtl/mfb_frame_lng_shaper.sv
// Token-bucket pacer for MFB frame-length descriptors with a one-entry output register.
// Optional statistics counters are enabled by defining FRAME_LNG_SHAPER_STATS_EN.
module mfb_frame_lng_shaper #(
    parameter int LNG_WIDTH     = 14,
    parameter int BUCKET_WIDTH  = 16,
    parameter int BUCKET_MAX    = 4096,
    parameter int REFILL_PERIOD = 16,
    parameter int REFILL_AMOUNT = 64
) (
    input  logic                        CLK,
    input  logic                        RESET,
    input  logic                        CFG_ENABLE,
    input  logic [LNG_WIDTH-1:0]        RX_LNG,
    input  logic                        RX_SRC_RDY,
    output logic                        RX_DST_RDY,
    output logic [LNG_WIDTH-1:0]        TX_LNG,
    output logic                        TX_SRC_RDY,
    input  logic                        TX_DST_RDY,
    output logic signed [BUCKET_WIDTH:0] BUCKET_LEVEL
`ifdef FRAME_LNG_SHAPER_STATS_EN
    ,
    input  logic                        STAT_CLR,
    output logic [31:0]                 STAT_FRAMES,
    output logic [31:0]                 STAT_CREDIT_STALLS
`endif
);

    localparam int CNT_W = (REFILL_PERIOD > 1) ? $clog2(REFILL_PERIOD) : 1;
    localparam int EXT_W = BUCKET_WIDTH + 2;
    localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(REFILL_PERIOD - 1);
    localparam logic signed [EXT_W-1:0] B_MAX    = EXT_W'(BUCKET_MAX);
    localparam logic signed [EXT_W-1:0] B_REFILL = EXT_W'(REFILL_AMOUNT);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t                       state, state_nxt;
    logic [CNT_W-1:0]             cnt;
    logic                         tick;
    logic signed [BUCKET_WIDTH:0] bucket;
    logic signed [EXT_W-1:0]      refilled, clamped, debit, bucket_sum;
    logic [LNG_WIDTH-1:0]         tx_lng;
    logic                         slot_free, credit_ok, admit;

    assign tick       = (cnt == CNT_LAST);
    assign slot_free  = (state == EMPTY) || TX_DST_RDY;
    assign credit_ok  = !bucket[BUCKET_WIDTH] || !CFG_ENABLE;
    assign RX_DST_RDY = slot_free && credit_ok;
    assign admit      = RX_SRC_RDY && RX_DST_RDY;

    assign TX_LNG       = tx_lng;
    assign TX_SRC_RDY   = (state == FULL);
    assign BUCKET_LEVEL = bucket;

    // Refill is clamped at the ceiling before the debit; the extra bit absorbs the pre-clamp sum.
    always_comb begin
        refilled = {bucket[BUCKET_WIDTH], bucket};
        if (tick)
            refilled = refilled + B_REFILL;
        clamped    = (refilled > B_MAX) ? B_MAX : refilled;
        debit      = (admit && CFG_ENABLE) ? EXT_W'(RX_LNG) : '0;
        bucket_sum = clamped - debit;
    end

    always_comb begin
        state_nxt = state;
        if (admit)
            state_nxt = FULL;
        else if (TX_DST_RDY)
            state_nxt = EMPTY;
    end

    always_ff @(posedge CLK) begin
        if (RESET)
            state <= EMPTY;
        else
            state <= state_nxt;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt    <= '0;
            bucket <= (BUCKET_WIDTH+1)'(BUCKET_MAX);
            tx_lng <= '0;
        end else begin
            cnt    <= tick ? '0 : cnt + 1'b1;
            bucket <= bucket_sum[BUCKET_WIDTH:0];
            if (admit)
                tx_lng <= RX_LNG;
        end
    end

`ifdef FRAME_LNG_SHAPER_STATS_EN
    logic [31:0] frames, stalls;

    assign STAT_FRAMES        = frames;
    assign STAT_CREDIT_STALLS = stalls;

    // Saturating counters; clear wins over a same-cycle increment.
    always_ff @(posedge CLK) begin
        if (RESET || STAT_CLR) begin
            frames <= '0;
            stalls <= '0;
        end else begin
            if (admit && frames != '1)
                frames <= frames + 1'b1;
            if (RX_SRC_RDY && slot_free && !credit_ok && stalls != '1)
                stalls <= stalls + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mfb_frame_lng_shaper.sv
// Directed self-checking bench for mfb_frame_lng_shaper (small bucket parameters).
module tb_mfb_frame_lng_shaper;

    localparam int LW = 9;
    localparam int BW = 10;

    logic                 CLK = 1'b0;
    logic                 RESET;
    logic                 CFG_ENABLE;
    logic [LW-1:0]        RX_LNG;
    logic                 RX_SRC_RDY;
    logic                 RX_DST_RDY;
    logic [LW-1:0]        TX_LNG;
    logic                 TX_SRC_RDY;
    logic                 TX_DST_RDY;
    logic signed [BW:0]   BUCKET_LEVEL;
`ifdef FRAME_LNG_SHAPER_STATS_EN
    logic                 STAT_CLR;
    logic [31:0]          STAT_FRAMES;
    logic [31:0]          STAT_CREDIT_STALLS;
`endif

    int n_pass = 0;
    int n_chk  = 0;

    mfb_frame_lng_shaper #(
        .LNG_WIDTH(LW), .BUCKET_WIDTH(BW), .BUCKET_MAX(64),
        .REFILL_PERIOD(4), .REFILL_AMOUNT(8)
    ) dut (
        .CLK(CLK), .RESET(RESET), .CFG_ENABLE(CFG_ENABLE),
        .RX_LNG(RX_LNG), .RX_SRC_RDY(RX_SRC_RDY), .RX_DST_RDY(RX_DST_RDY),
        .TX_LNG(TX_LNG), .TX_SRC_RDY(TX_SRC_RDY), .TX_DST_RDY(TX_DST_RDY),
        .BUCKET_LEVEL(BUCKET_LEVEL)
`ifdef FRAME_LNG_SHAPER_STATS_EN
        ,
        .STAT_CLR(STAT_CLR), .STAT_FRAMES(STAT_FRAMES),
        .STAT_CREDIT_STALLS(STAT_CREDIT_STALLS)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    // Leaves the bench 1 time unit into cycle 0 (refill counter 0).
    task automatic do_reset();
        RESET      = 1'b1;
        CFG_ENABLE = 1'b1;
        RX_SRC_RDY = 1'b0;
        RX_LNG     = '0;
        TX_DST_RDY = 1'b1;
`ifdef FRAME_LNG_SHAPER_STATS_EN
        STAT_CLR   = 1'b0;
`endif
        cyc();
        cyc();
        RESET = 1'b0;
    endtask

    int exp_b;

    initial begin
        // Idle after reset
        do_reset();
        #1;
        chk("rst_tx_lng", int'(TX_LNG), 0);
        for (int c = 0; c < 100; c++) begin
            chk("idle_bucket", int'(BUCKET_LEVEL), 64);
            chk("idle_tx_vld", int'(TX_SRC_RDY), 0);
            chk("idle_rx_rdy", int'(RX_DST_RDY), 1);
            cyc();
            #1;
        end

        // Single 100-item frame drives the bucket negative
        do_reset();
        RX_LNG = 100; RX_SRC_RDY = 1'b1;
        #1;
        chk("s1_c0_rdy", int'(RX_DST_RDY), 1);
        cyc();
        RX_LNG = 5;
        #1;
        chk("s1_tx_vld", int'(TX_SRC_RDY), 1);
        chk("s1_tx_lng", int'(TX_LNG), 100);
        chk("s1_bucket", int'(BUCKET_LEVEL), -36);
        chk("s1_rdy_lo", int'(RX_DST_RDY), 0);
        exp_b = -36;
        for (int c = 2; c < 20; c++) begin
            cyc();
            if ((c - 1) % 4 == 3) exp_b += 8;
            #1;
            if (c == 2) chk("s1_tx_drained", int'(TX_SRC_RDY), 0);
            chk("s1_refill", int'(BUCKET_LEVEL), exp_b);
            chk("s1_stall_rdy", int'(RX_DST_RDY), 0);
        end
        cyc();
        RX_SRC_RDY = 1'b0;
        #1;
        chk("s1_c20_bucket", int'(BUCKET_LEVEL), 4);
        chk("s1_c20_rdy", int'(RX_DST_RDY), 1);
`ifdef FRAME_LNG_SHAPER_STATS_EN
        chk("s1_stalls", int'(STAT_CREDIT_STALLS), 19);
        chk("s1_frames", int'(STAT_FRAMES), 1);
`endif

        // Burst of five 16-item frames starting on a refill tick (clamp active)
        begin
            int exp_bb[5] = '{48, 32, 16, 0, -8};
            do_reset();
            cyc(); cyc(); cyc();
            RX_LNG = 16; RX_SRC_RDY = 1'b1;
            #1;
            chk("b2b_rdy0", int'(RX_DST_RDY), 1);
            for (int k = 0; k < 5; k++) begin
                cyc();
                if (k == 4) RX_SRC_RDY = 1'b0;
                #1;
                chk("b2b_tx_vld", int'(TX_SRC_RDY), 1);
                chk("b2b_tx_lng", int'(TX_LNG), 16);
                chk("b2b_bucket", int'(BUCKET_LEVEL), exp_bb[k]);
                chk("b2b_rdy", int'(RX_DST_RDY), (k < 4) ? 1 : 0);
            end
        end

        // Backpressure holds the entry; release swaps 10 out and 20 in
        do_reset();
        TX_DST_RDY = 1'b0;
        RX_LNG = 10; RX_SRC_RDY = 1'b1;
        #1;
        chk("bp_rdy0", int'(RX_DST_RDY), 1);
        cyc();
        RX_LNG = 20;
        for (int c = 1; c < 3; c++) begin
            #1;
            chk("bp_hold_lng", int'(TX_LNG), 10);
            chk("bp_hold_vld", int'(TX_SRC_RDY), 1);
            chk("bp_rdy_lo", int'(RX_DST_RDY), 0);
            cyc();
        end
        TX_DST_RDY = 1'b1;
        #1;
        chk("bp_release_rdy", int'(RX_DST_RDY), 1);
        cyc();
        RX_SRC_RDY = 1'b0;
        #1;
        chk("bp_next_lng", int'(TX_LNG), 20);
        chk("bp_next_vld", int'(TX_SRC_RDY), 1);
        chk("bp_bucket", int'(BUCKET_LEVEL), 42);

        // Shaping disabled: pass-through at full rate, no debit
        do_reset();
        CFG_ENABLE = 1'b0;
        RX_LNG = 200; RX_SRC_RDY = 1'b1;
        for (int k = 0; k < 10; k++) begin
            cyc();
            if (k == 9) RX_SRC_RDY = 1'b0;
            #1;
            chk("dis_tx_lng", int'(TX_LNG), 200);
            chk("dis_tx_vld", int'(TX_SRC_RDY), 1);
            chk("dis_bucket", int'(BUCKET_LEVEL), 64);
            chk("dis_rdy", int'(RX_DST_RDY), 1);
        end

        // Zero-length frame passes without debit
        do_reset();
        RX_LNG = 0; RX_SRC_RDY = 1'b1;
        cyc();
        RX_SRC_RDY = 1'b0;
        #1;
        chk("zero_vld", int'(TX_SRC_RDY), 1);
        chk("zero_lng", int'(TX_LNG), 0);
        chk("zero_bucket", int'(BUCKET_LEVEL), 64);

        // Reset while FULL with a negative bucket
        do_reset();
        TX_DST_RDY = 1'b0;
        RX_LNG = 100; RX_SRC_RDY = 1'b1;
        cyc();
        RX_SRC_RDY = 1'b0;
        #1;
        chk("mr_pre_vld", int'(TX_SRC_RDY), 1);
        chk("mr_pre_bucket", int'(BUCKET_LEVEL), -36);
        RESET = 1'b1;
        cyc();
        RESET = 1'b0;
        #1;
        chk("mr_vld", int'(TX_SRC_RDY), 0);
        chk("mr_lng", int'(TX_LNG), 0);
        chk("mr_bucket", int'(BUCKET_LEVEL), 64);
        chk("mr_rdy", int'(RX_DST_RDY), 1);
`ifdef FRAME_LNG_SHAPER_STATS_EN
        chk("mr_frames", int'(STAT_FRAMES), 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
